// File: rtl/event_recorder_if.sv
// Record stream handshake between the event recorder (master) and its consumer (slave).
// The record is valid while rec_valid=1 and leaves on a cycle with rec_ready=1.
interface event_recorder_if #(
  parameter int DATA_WIDTH = 43
);
  logic                  rec_valid;
  logic [DATA_WIDTH-1:0] rec_data;
  logic                  rec_ready;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/event_recorder.sv
// Event recorder: timestamps every enabled cycle with activity on L1A/ALCT_DAV/TMB_DAV/LCT
// and queues {ts, l1a, alct_dav, tmb_dav, lct} in a first-word-fall-through FIFO.
module event_recorder #(
  parameter int TS_WIDTH   = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int DROP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_l1a,
  input  logic                  i_alct_dav,
  input  logic                  i_tmb_dav,
  input  logic [7:0]            i_lct,
  input  logic                  i_ovfl_clr,
  event_recorder_if.master      rec_if,
  output logic [DEPTH_LOG2:0]   o_fifo_cnt,
  output logic [TS_WIDTH-1:0]   o_ts_cnt,
  output logic                  o_ovfl,
  output logic [DROP_WIDTH-1:0] o_drop_cnt
);

  localparam int REC_W = TS_WIDTH + 11;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [REC_W-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_cnt;
  logic [TS_WIDTH-1:0]   r_ts;
  logic                  r_ovfl;
  logic [DROP_WIDTH-1:0] r_drop;

  logic             w_capture;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [REC_W-1:0] w_rec;

  assign w_capture = i_en & (i_l1a | i_alct_dav | i_tmb_dav | (|i_lct));
  assign w_full    = (r_cnt == FULL_CNT);
  assign w_empty   = (r_cnt == '0);
  assign w_pop     = ~w_empty & rec_if.rec_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;
  assign w_rec     = {r_ts, i_l1a, i_alct_dav, i_tmb_dav, i_lct};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts <= '0;
    end else if (i_en) begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (DEPTH_LOG2 + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves exactly that one drop counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovfl <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovfl <= 1'b1;
      if (i_ovfl_clr) begin
        r_drop <= DROP_WIDTH'(1);
      end else if (r_drop != '1) begin
        r_drop <= r_drop + DROP_WIDTH'(1);
      end
    end else if (i_ovfl_clr) begin
      r_ovfl <= 1'b0;
      r_drop <= '0;
    end
  end

  assign rec_if.rec_valid = ~w_empty;
  assign rec_if.rec_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_fifo_cnt       = r_cnt;
  assign o_ts_cnt         = r_ts;
  assign o_ovfl           = r_ovfl;
  assign o_drop_cnt       = r_drop;

endmodule
